// File: rtl/if_fetch_queue_pkg.sv
// Shared constants for the instruction-fetch queue slice: default queue depth
// and the PC / instruction widths used by the fetch front end.
package if_fetch_queue_pkg;

  localparam int FQ_DEPTH = 4;
  localparam int FQ_ISIZE = 32;
  localparam int FQ_DSIZE = 32;

endpackage

// File: rtl/if_fetch_queue_if.sv
// Bundle of the fetch queue's external buses: the instruction-memory read port,
// the redirect input from downstream, and the valid/ready port toward ID.
// "master" is the fetch-queue side, "slave" is the surrounding pipeline.
interface if_fetch_queue_if
  import if_fetch_queue_pkg::*;
#(
  parameter int DEPTH = FQ_DEPTH,
  parameter int ISIZE = FQ_ISIZE,
  parameter int DSIZE = FQ_DSIZE
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic             imem_req;
  logic [ISIZE-1:0] imem_addr;
  logic [DSIZE-1:0] imem_data;
  logic             redirect;
  logic [ISIZE-1:0] redirect_pc;
  logic             id_valid;
  logic             id_ready;
  logic [DSIZE-1:0] id_inst;
  logic [ISIZE-1:0] id_pc;
  logic [ISIZE-1:0] id_npc;
  logic [CW-1:0]    fq_count;

  modport master (
    output imem_req, imem_addr,
    input  imem_data,
    input  redirect, redirect_pc,
    output id_valid,
    input  id_ready,
    output id_inst, id_pc, id_npc, fq_count
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_data,
    output redirect, redirect_pc,
    input  id_valid,
    output id_ready,
    input  id_inst, id_pc, id_npc, fq_count
  );

endinterface

// File: rtl/if_fetch_queue_fq_fifo.sv
// Small synchronous FIFO holding {instruction, pc} pairs. The head is read
// straight out of the storage registers, so nothing written this cycle is
// visible at the head until the next cycle. Flush empties it in one cycle.
module fq_fifo
  import if_fetch_queue_pkg::*;
#(
  parameter int DEPTH = FQ_DEPTH,
  parameter int ISIZE = FQ_ISIZE,
  parameter int DSIZE = FQ_DSIZE,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [DSIZE-1:0] push_inst,
  input  logic [ISIZE-1:0] push_pc,
  input  logic             pop,
  output logic             head_vld,
  output logic [DSIZE-1:0] head_inst,
  output logic [ISIZE-1:0] head_pc,
  output logic [CW-1:0]    count
);

  logic [DSIZE-1:0] inst_mem [DEPTH];
  logic [ISIZE-1:0] pc_mem   [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;

  // Pointer and occupancy control; pointers wrap naturally mod DEPTH.
  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage; payload registers carry no reset.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      inst_mem[wr_ptr] <= push_inst;
      pc_mem[wr_ptr]   <= push_pc;
    end
  end

  // Head view taken from the registered storage.
  always_comb begin
    head_vld  = (count != '0);
    head_inst = inst_mem[rd_ptr];
    head_pc   = pc_mem[rd_ptr];
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
    !(push && !pop && !flush && (count == CW'(DEPTH))));

  a_no_underflow: assert property (@(posedge clk) disable iff (!rst)
    !(pop && !flush && (count == '0)));

endmodule

// File: rtl/if_fetch_queue.sv
// Instruction-fetch front end. Owns the fetch PC, issues one word read per
// cycle to a 1-cycle-latency instruction memory while the queue has room for
// the result, and hands buffered {inst, pc, pc+1} to ID over valid/ready.
// A redirect flushes the queue, drops the read returning that cycle, and
// restarts fetch at redirect_pc in the same cycle.
module if_fetch_queue
  import if_fetch_queue_pkg::*;
#(
  parameter int               DEPTH    = FQ_DEPTH,
  parameter int               ISIZE    = FQ_ISIZE,
  parameter int               DSIZE    = FQ_DSIZE,
  parameter logic [ISIZE-1:0] RESET_PC = '0
) (
  input logic            clk,
  input logic            rst,
  if_fetch_queue_if.master bus
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [ISIZE-1:0] fetch_pc;
  logic [ISIZE-1:0] issue_addr;
  logic             issue;
  logic             credit;
  logic [CW:0]      occ;
  logic             vld_p1;
  logic [ISIZE-1:0] inflight_pc_p1;
  logic             push;
  logic             pop;
  logic             head_vld;
  logic [DSIZE-1:0] head_inst;
  logic [ISIZE-1:0] head_pc;
  logic [CW-1:0]    count;
  logic             out_vld;
  logic [ISIZE-1:0] out_pc;

  // Issue decision: a redirect always fetches; otherwise only fetch while the
  // queue plus the outstanding read leaves room for one more entry. A pop this
  // cycle is deliberately not counted, keeping credit off the ID ready path.
  always_comb begin
    occ        = {1'b0, count} + (CW + 1)'(vld_p1);
    credit     = (occ < (CW + 1)'(DEPTH));
    issue      = rst & (bus.redirect | credit);
    issue_addr = bus.redirect ? bus.redirect_pc : fetch_pc;
    // The response landing during a redirect belongs to the old stream.
    push       = rst & vld_p1 & ~bus.redirect;
    pop        = head_vld & bus.id_ready & ~bus.redirect;
  end

  // Fetch PC and in-flight read tracking (control state).
  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_pc <= RESET_PC;
      vld_p1   <= 1'b0;
    end else begin
      vld_p1 <= issue;
      if (issue) fetch_pc <= issue_addr + ISIZE'(1);
    end
  end

  // PC of the outstanding read, paired with the data arriving next cycle.
  always_ff @(posedge clk) begin
    if (issue) inflight_pc_p1 <= issue_addr;
  end

  // ---- response stage: memory data joins its pc and enters the queue ----
  fq_fifo #(
    .DEPTH (DEPTH),
    .ISIZE (ISIZE),
    .DSIZE (DSIZE)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (bus.redirect),
    .push      (push),
    .push_inst (bus.imem_data),
    .push_pc   (inflight_pc_p1),
    .pop       (pop),
    .head_vld  (head_vld),
    .head_inst (head_inst),
    .head_pc   (head_pc),
    .count     (count)
  );

  // ID-facing outputs, forced to their idle values while reset is held.
  always_comb begin
    out_vld       = rst & head_vld;
    out_pc        = out_vld ? head_pc : '0;
    bus.imem_req  = issue;
    bus.imem_addr = issue_addr;
    bus.id_valid  = out_vld;
    bus.id_inst   = out_vld ? head_inst : '0;
    bus.id_pc     = out_pc;
    bus.id_npc    = out_pc + ISIZE'(1);
    bus.fq_count  = rst ? count : '0;
  end

endmodule
